// File: rtl/dilithium_pkg.sv
// Shared constants for the Dilithium verify wrapper: operation modes, field ids
// and per-level field sizes expressed in words of the stream width.
package dilithium_pkg;

   localparam logic [1:0] KEYGEN_MODE = 2'd0;
   localparam logic [1:0] SIGN_MODE   = 2'd1;
   localparam logic [1:0] VERIFY_MODE = 2'd2;

   // FLD_END tells the core that no field is being loaded
   typedef enum logic [2:0] {
      FLD_RHO, FLD_C, FLD_Z, FLD_T1, FLD_MLEN, FLD_MSG, FLD_H, FLD_END
   } fld_e;

   function automatic int k_of(input int lvl);
      case (lvl)
         32'sd3:  return 32'sd6;
         32'sd5:  return 32'sd8;
         default: return 32'sd4;
      endcase
   endfunction

   function automatic int l_of(input int lvl);
      case (lvl)
         32'sd3:  return 32'sd5;
         32'sd5:  return 32'sd7;
         default: return 32'sd4;
      endcase
   endfunction

   function automatic int gamma1_bits_of(input int lvl);
      case (lvl)
         32'sd2:  return 32'sd18;
         default: return 32'sd20;
      endcase
   endfunction

   function automatic int omega_of(input int lvl);
      case (lvl)
         32'sd3:  return 32'sd55;
         32'sd5:  return 32'sd75;
         default: return 32'sd80;
      endcase
   endfunction

   function automatic int seed_words(input int w);
      return 32'sd256 / w;
   endfunction

   function automatic int z_words(input int w, input int lvl);
      return l_of(lvl) * 32'sd256 * gamma1_bits_of(lvl) / w;
   endfunction

   function automatic int t1_words(input int w, input int lvl);
      return k_of(lvl) * 32'sd2560 / w;
   endfunction

   function automatic int h_words(input int w, input int lvl);
      return ((omega_of(lvl) + k_of(lvl)) * 32'sd8 + w - 32'sd1) / w;
   endfunction

endpackage

// File: rtl/dilithium_verify_core.sv
// Stand-in verify core: folds every streamed word into a XOR digest and accepts
// when the digest is zero. The arithmetic datapath plugs in behind the same handshake.
module dilithium_verify_core
   import dilithium_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  fld_e         fld_id,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         res_valid,
   output logic         res_accept,
   input  logic         res_ready
);

   logic [W-1:0] acc_r;
   logic         busy_r;
   logic         res_valid_r;
   logic         res_accept_r;

   assign in_ready   = ~res_valid_r;
   assign res_valid  = res_valid_r;
   assign res_accept = res_accept_r;

   // Digest accumulation; the verdict is formed once the wrapper stops loading
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r        <= {W{1'b0}};
         busy_r       <= 1'b0;
         res_valid_r  <= 1'b0;
         res_accept_r <= 1'b0;
      end else if (res_valid_r && res_ready) begin
         acc_r        <= {W{1'b0}};
         busy_r       <= 1'b0;
         res_valid_r  <= 1'b0;
         res_accept_r <= 1'b0;
      end else if (!res_valid_r && busy_r && (fld_id == FLD_END)) begin
         res_valid_r  <= 1'b1;
         res_accept_r <= (acc_r == {W{1'b0}});
      end else if (in_valid && in_ready) begin
         acc_r  <= acc_r ^ in_data;
         busy_r <= 1'b1;
      end
   end

endmodule

// File: rtl/dilithium.sv
// Dilithium verify-path wrapper: sequences the streamed key/signature/message
// fields into the verify core and returns a one-word verdict.
module dilithium
   import dilithium_pkg::*;
#(
   parameter int HIGH_PERF = 1,
   parameter int SEC_LEVEL = 2,
   parameter int W         = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic         valid_i,
   output logic         ready_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_o,
   output logic [W-1:0] data_o
);

   localparam logic [W-1:0] SEED_WORDS = W'(seed_words(W));
   localparam logic [W-1:0] Z_WORDS    = W'(z_words(W, SEC_LEVEL));
   localparam logic [W-1:0] T1_WORDS   = W'(t1_words(W, SEC_LEVEL));
   localparam logic [W-1:0] H_WORDS    = W'(h_words(W, SEC_LEVEL));
   localparam logic [W-1:0] ONE_WORD   = {{(W-1){1'b0}}, 1'b1};
   localparam logic         HP_BIT     = (HIGH_PERF != 0) ? 1'b1 : 1'b0;

   typedef enum logic [3:0] {
      ST_IDLE, ST_RHO, ST_C, ST_Z, ST_T1, ST_MLEN, ST_MSG, ST_H, ST_RESULT
   } state_e;

   state_e       state_r, state_s;
   logic [W-1:0] cnt_r, mlen_r, words_s, msg_words_s;
   logic         valid_o_r;
   logic [W-1:0] data_o_r;
   fld_e         fld_s;
   logic         load_s, xfer_s, last_s;
   logic         core_in_ready_s, res_valid_s, res_accept_s, res_ready_s;

   // An empty message still occupies one word
   function automatic logic [W-1:0] msg_words_of(input logic [W-1:0] m);
      logic [W+3:0] bits;
      bits = {1'b0, m, 3'b000};
      if (m == {W{1'b0}}) return ONE_WORD;
      return W'((bits + (W+4)'(W - 1)) / (W+4)'(W));
   endfunction

   function automatic state_e next_field(input state_e s);
      if (HIGH_PERF != 0) begin
         case (s)
            ST_RHO:  return ST_C;
            ST_C:    return ST_Z;
            ST_Z:    return ST_T1;
            ST_T1:   return ST_MLEN;
            ST_MLEN: return ST_MSG;
            ST_MSG:  return ST_H;
            default: return ST_RESULT;
         endcase
      end else begin
         case (s)
            ST_RHO:  return ST_T1;
            ST_T1:   return ST_C;
            ST_C:    return ST_Z;
            ST_Z:    return ST_H;
            ST_H:    return ST_MLEN;
            ST_MLEN: return ST_MSG;
            default: return ST_RESULT;
         endcase
      end
   endfunction

   assign msg_words_s = msg_words_of(mlen_r);

   // Field id and length of the field currently being loaded
   always_comb begin
      fld_s   = FLD_END;
      words_s = ONE_WORD;
      load_s  = 1'b1;
      case (state_r)
         ST_RHO:  begin fld_s = FLD_RHO;  words_s = SEED_WORDS;  end
         ST_C:    begin fld_s = FLD_C;    words_s = SEED_WORDS;  end
         ST_Z:    begin fld_s = FLD_Z;    words_s = Z_WORDS;     end
         ST_T1:   begin fld_s = FLD_T1;   words_s = T1_WORDS;    end
         ST_MLEN: begin fld_s = FLD_MLEN; words_s = ONE_WORD;    end
         ST_MSG:  begin fld_s = FLD_MSG;  words_s = msg_words_s; end
         ST_H:    begin fld_s = FLD_H;    words_s = H_WORDS;     end
         default: load_s = 1'b0;
      endcase
   end

   assign ready_i     = load_s & core_in_ready_s;
   assign xfer_s      = load_s & valid_i & core_in_ready_s;
   assign last_s      = (cnt_r == (words_s - ONE_WORD));
   assign res_ready_s = (state_r == ST_RESULT) & ~valid_o_r & res_valid_s;

   // Next-state: field advance happens on the last word, no gap cycle
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && (mode == VERIFY_MODE)) state_s = ST_RHO;
            else                                state_s = ST_IDLE;
         end
         ST_RHO, ST_C, ST_Z, ST_T1, ST_MLEN, ST_MSG, ST_H: begin
            if (xfer_s && last_s) state_s = next_field(state_r);
            else                  state_s = state_r;
         end
         ST_RESULT: begin
            if (valid_o_r && ready_o) state_s = ST_IDLE;
            else                      state_s = ST_RESULT;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, per-field word counter and latched message length
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {W{1'b0}};
         mlen_r  <= {W{1'b0}};
      end else begin
         state_r <= state_s;
         if (xfer_s) cnt_r <= last_s ? {W{1'b0}} : (cnt_r + ONE_WORD);
         else if (state_r == ST_IDLE) cnt_r <= {W{1'b0}};
         if (xfer_s && (state_r == ST_MLEN)) mlen_r <= data_i;
      end
   end

   // Verdict register, held until the consumer takes it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o_r <= 1'b0;
         data_o_r  <= {W{1'b0}};
      end else if (res_ready_s) begin
         valid_o_r <= 1'b1;
         data_o_r  <= {{(W-1){1'b0}}, res_accept_s ^ HP_BIT};
      end else if (valid_o_r && ready_o) begin
         valid_o_r <= 1'b0;
         data_o_r  <= {W{1'b0}};
      end
   end

   assign valid_o = valid_o_r;
   assign data_o  = data_o_r;

   dilithium_verify_core #(.W(W)) u_core (
      .clk        (clk),
      .rst        (rst),
      .fld_id     (fld_s),
      .in_valid   (load_s & valid_i),
      .in_ready   (core_in_ready_s),
      .in_data    (data_i),
      .res_valid  (res_valid_s),
      .res_accept (res_accept_s),
      .res_ready  (res_ready_s)
   );

endmodule

// File: tb/tb_dilithium.sv
// Directed bench: instance 0 is level 2 / HIGH_PERF=1, instance 1 is level 3 / HIGH_PERF=0.
module tb_dilithium;

   localparam int W = 64;
   localparam int F_RHO = 0, F_C = 1, F_Z = 2, F_T1 = 3, F_MLEN = 4, F_MSG = 5, F_H = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [1:0]          start_v, valid_v, ready_o_v;
   logic [1:0][1:0]     mode_v;
   logic [1:0][W-1:0]   data_v;
   logic                ready_i0, ready_i1, valid_o0, valid_o1;
   logic [W-1:0]        data_o0, data_o1;

   int n_checks = 0;
   int n_errors = 0;

   dilithium #(.HIGH_PERF(1), .SEC_LEVEL(2), .W(W)) dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
      .valid_i(valid_v[0]), .ready_i(ready_i0), .data_i(data_v[0]),
      .valid_o(valid_o0), .ready_o(ready_o_v[0]), .data_o(data_o0));

   dilithium #(.HIGH_PERF(0), .SEC_LEVEL(3), .W(W)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
      .valid_i(valid_v[1]), .ready_i(ready_i1), .data_i(data_v[1]),
      .valid_o(valid_o1), .ready_o(ready_o_v[1]), .data_o(data_o1));

   function automatic logic rdy(input int d);
      return (d == 0) ? ready_i0 : ready_i1;
   endfunction

   function automatic logic vo(input int d);
      return (d == 0) ? valid_o0 : valid_o1;
   endfunction

   function automatic logic [W-1:0] dout(input int d);
      return (d == 0) ? data_o0 : data_o1;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Hand-derived field sizes at W=64 for levels 2 and 3
   function automatic int fld_words(input int f, input int lvl, input int mlen);
      case (f)
         F_RHO, F_C: return 4;
         F_Z:        return (lvl == 2) ? 288 : 400;
         F_T1:       return (lvl == 2) ? 160 : 240;
         F_MLEN:     return 1;
         F_MSG:      return (mlen == 0) ? 1 : (mlen * 8 + 63) / 64;
         F_H:        return (lvl == 2) ? 11 : 8;
         default:    return 0;
      endcase
   endfunction

   task automatic pulse_start(input int d, input logic [1:0] m);
      @(negedge clk);
      start_v[d] = 1'b1;
      mode_v[d]  = m;
      @(negedge clk);
      start_v[d] = 1'b0;
      mode_v[d]  = 2'd0;
   endtask

   // Builds a stream whose words XOR to zero (good vector), optionally flips one bit
   // of the first word of bad_fld, streams it and checks the verdict handshake.
   task automatic run_verify(input int d, input int mlen, input int bad_fld, input int gap,
                             input int hold, input int abort_at, input logic [63:0] exp);
      logic [W-1:0] q[$];
      logic [W-1:0] acc;
      int ord[7];
      int lvl, bad_idx, n;
      lvl = (d == 0) ? 2 : 3;
      if (d == 0) ord = '{F_RHO, F_C, F_Z, F_T1, F_MLEN, F_MSG, F_H};
      else        ord = '{F_RHO, F_T1, F_C, F_Z, F_H, F_MLEN, F_MSG};
      acc = '0;
      bad_idx = -1;
      foreach (ord[k]) begin
         if (ord[k] == bad_fld) bad_idx = q.size();
         for (int i = 0; i < fld_words(ord[k], lvl, mlen); i++) begin
            logic [W-1:0] w;
            w = (ord[k] == F_MLEN) ? 64'(mlen) : {$urandom(), $urandom()};
            q.push_back(w);
            acc = acc ^ w;
         end
      end
      q[q.size() - 1] = q[q.size() - 1] ^ acc;
      if (bad_idx >= 0) q[bad_idx] = q[bad_idx] ^ 64'h20;

      ready_o_v[d] = (hold == 0);
      pulse_start(d, 2'd2);
      for (int i = 0; i < q.size(); i++) begin
         if (abort_at >= 0 && i == abort_at) return;
         repeat (gap) begin
            @(negedge clk);
            valid_v[d] = 1'b0;
         end
         @(negedge clk);
         valid_v[d] = 1'b1;
         data_v[d]  = q[i];
         n = 0;
         while (!rdy(d) && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) begin
            check("load_ready_timeout", 64'(rdy(d)), 64'd1);
            valid_v[d] = 1'b0;
            return;
         end
         @(posedge clk);
      end
      // Offer an excess word: it must not be taken
      @(negedge clk);
      valid_v[d] = 1'b1;
      data_v[d]  = '1;
      check("ready_after_load", 64'(rdy(d)), 64'd0);
      n = 0;
      while (!vo(d) && n < 20) begin
         @(negedge clk);
         n++;
      end
      valid_v[d] = 1'b0;
      check("valid_o_rise", 64'(vo(d)), 64'd1);
      check("verdict", dout(d), exp);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check("hold_valid_o", 64'(vo(d)), 64'd1);
            check("hold_data_o", dout(d), exp);
         end
         ready_o_v[d] = 1'b1;
      end
      @(negedge clk);
      check("valid_o_clear", 64'(vo(d)), 64'd0);
      check("data_o_clear", dout(d), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      start_v   = '0;
      valid_v   = '0;
      ready_o_v = 2'b11;
      mode_v    = '0;
      data_v    = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_ready_i", 64'(rdy(d)), 64'd0);
         check("reset_valid_o", 64'(vo(d)), 64'd0);
         check("reset_data_o", dout(d), 64'd0);
      end
      rst = 1'b1;

      // Non-verify modes are ignored
      pulse_start(0, 2'd0);
      check("mode0_ready_i", 64'(rdy(0)), 64'd0);
      pulse_start(0, 2'd1);
      check("mode1_ready_i", 64'(rdy(0)), 64'd0);
      pulse_start(1, 2'd3);
      check("mode3_ready_i", 64'(rdy(1)), 64'd0);

      // Level 2, HIGH_PERF=1: 0 = accept, 1 = reject
      run_verify(0, 16, -1,   0, 0, -1, 64'd0);
      run_verify(0, 16, F_Z,  0, 0, -1, 64'd1);
      run_verify(0, 0,  -1,   0, 0, -1, 64'd0);
      run_verify(0, 9,  -1,   0, 0, -1, 64'd0);
      run_verify(0, 5,  -1,   2, 5, -1, 64'd0);

      // Level 3, HIGH_PERF=0: 1 = accept, 0 = reject
      run_verify(1, 9,  -1,   0, 0, -1, 64'd1);
      run_verify(1, 9,  F_C,  0, 0, -1, 64'd0);
      run_verify(1, 0,  -1,   0, 0, -1, 64'd1);
      run_verify(1, 21, F_H,  1, 2, -1, 64'd0);

      // Reset in the middle of Z, then a clean run
      run_verify(0, 16, -1, 0, 0, 100, 64'd0);
      #2;
      check("pre_reset_ready_i", 64'(rdy(0)), 64'd1);
      valid_v[0] = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_ready_i", 64'(rdy(0)), 64'd0);
      check("midrst_valid_o", 64'(vo(0)), 64'd0);
      check("midrst_data_o", dout(0), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_verify(0, 16, -1, 0, 0, -1, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dilithium.md
Name: dilithium

Overview:
- Top-level CRYSTALS-Dilithium verify-path wrapper. Accepts a streamed public key, signature and message over a W-bit valid/ready input channel in a fixed field order; returns a one-word accept/reject verdict over a W-bit valid/ready output channel.
- Owns framing only: field sequencing, word counting and result formatting.
- All polynomial/hash arithmetic lives in the sub-module dilithium_verify_core.

Parameters:
- HIGH_PERF, 1: field ordering and result encoding variant (1 = high-performance, 0 = low-resource).
- SEC_LEVEL, 2: Dilithium level 2/3/5. Selects K, L, GAMMA1 bits and OMEGA.
- W, 64: data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins an operation.
- mode  in  2  operation select: 0 keygen, 1 sign, 2 verify.
- valid_i  in  1  data_i holds a valid word.
- ready_i  out  1  block accepts a word this cycle.
- data_i  in  W  input word.
- valid_o  out  1  data_o holds the result.
- ready_o  in  1  consumer accepts the result.
- data_o  out  W  result word.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; ready_i=0, valid_o=0, data_o=0. Reset mid-operation aborts the operation and discards buffered data.
- Input transfer occurs on a clock edge where valid_i && ready_i. Output transfer occurs on a clock edge where valid_o && ready_o.
- Words are MSB-first: word n carries field bits [n*W +: W], bit 0 = first bit.
- Field word counts:
  - SEED_WORDS = 256/W (rho, c).
  - Z_WORDS = L*256*(GAMMA1_BITS)/W. At W=64: 288/400/560 for levels 2/3/5.
  - T1_WORDS = K*2560/W. At W=64: 160/240/320.
  - H_WORDS = ceil((OMEGA+K)*8/W). At W=64: 11/8/11.
  - MLEN = 1 word holding the message byte length.
  - MSG_WORDS = max(1, ceil(mlen*8/W)).
- IDLE:
  - start=1 with mode=2 moves to the first load state.
  - start with any other mode is ignored; the block stays in IDLE.
  - start outside IDLE is ignored.
- Load order, HIGH_PERF=1: RHO, C, Z, T1, MLEN, MSG, H, then RESULT.
- Load order, HIGH_PERF=0: RHO, T1, C, Z, H, MLEN, MSG, then RESULT.
- Load states:
  - ready_i is driven from the core's in_ready.
  - Each transfer forwards the word plus a field id to the core and increments a word counter.
  - On the last word of a field: clear the counter and advance to the next field in the same cycle. No idle cycle between fields.
  - valid_i low stalls without penalty.
  - ready_i is 0 in IDLE and RESULT.
- MLEN: the transferred word is latched as mlen and forwarded to the core. MSG_WORDS is computed from it.
- RESULT:
  - Wait for the core's res_valid, then assert valid_o with data_o = {(W-1)'0, accept ^ HIGH_PERF}.
  - With HIGH_PERF=1, 0 = accept and 1 = reject. With HIGH_PERF=0, 1 = accept and 0 = reject.
  - Hold valid_o and data_o stable until ready_o. On transfer: valid_o=0, data_o=0, return to IDLE.
  - A new start is then accepted the next cycle.
- Excess words (valid_i while in RESULT or IDLE) are not accepted.

Decomposition:
- Package dilithium_pkg contains:
  - mode constants KEYGEN/SIGN/VERIFY_MODE=2;
  - field-id enum;
  - per-level K, L, GAMMA1_BITS, OMEGA;
  - derived *_WORDS functions of W and SEC_LEVEL.
- One sub-module, dilithium_verify_core. It is a separate deliverable.
  - Interface: fld_id, in_valid, in_ready, in_data[W], res_valid, res_accept, res_ready.
  - It computes the verify result.
- This block is the sequencer FSM, counters, mlen register and output register.

Test Plan:
- Level 2, HIGH_PERF=1, known-good test vector 0, ready_o high. Transfer counts must be 4+4+288+160+1+ceil(mlen/8)+11, and data_o must be 0 (accept).
- Same vector with one bit of z flipped: data_o=1 (reject).
- HIGH_PERF=0, level 3, good vector with order rho, t1, c, z, h, mlen, msg: data_o=1. Corrupted c: data_o=0.
- mlen=0: exactly 1 MSG word is accepted before H/RESULT. mlen=9 with W=64: exactly 2 MSG words.
- valid_i toggled 1-of-3 cycles and ready_o held low 5 cycles after valid_o: no words are lost, and valid_o/data_o stay stable until ready_o.
- Edge cases:
  - start with mode=0: ready_i stays 0.
  - rst low mid-Z load: outputs go to 0 immediately, and a fresh run afterwards passes.
